// File: rtl/iob_eth_rx_ctrl_pkg.sv
// Shared definitions for the ping-pong Ethernet RX buffer controller:
// FSM state encodings, bank count and the free-bank selection helper.
package iob_eth_rx_ctrl_pkg;

   localparam int NUM_BANKS = 2;

   typedef enum logic [2:0] {
      ST_DIS   = 3'd0,
      ST_ARM   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SW    = 3'd3,
      ST_STALL = 3'd4
   } state_t;

   // With an empty queue the read pointer names the next bank in arrival order;
   // with one frame queued (always at rd_ptr) the other bank is the free one.
   function automatic logic pick_free_bank(input logic [NUM_BANKS-1:0] full, input logic rd_ptr);
      if (full == 2'b00) begin
         return rd_ptr;
      end else begin
         return ~rd_ptr;
      end
   endfunction

endpackage

// File: rtl/iob_eth_rx_ctrl_if.sv
// Receiver-side and host-side signals of the RX buffer controller.
// The slave modport is the controller; the master modport drives receiver and host inputs.
interface iob_eth_rx_ctrl_if #(
   parameter int BUF_ADDR_W = 11,
   parameter int DROP_W     = 16
);

   logic                  rx_ready;
   logic [BUF_ADDR_W-1:0] rx_nbytes;
   logic                  rx_sof;
   logic                  rx_rearm;
   logic                  rx_bank;
   logic                  host_valid;
   logic                  host_bank;
   logic [BUF_ADDR_W-1:0] host_nbytes;
   logic                  host_ack;
   logic [DROP_W-1:0]     drop_cnt;

   modport master (
      output rx_ready, rx_nbytes, rx_sof, host_ack,
      input  rx_rearm, rx_bank, host_valid, host_bank, host_nbytes, drop_cnt
   );

   modport slave (
      input  rx_ready, rx_nbytes, rx_sof, host_ack,
      output rx_rearm, rx_bank, host_valid, host_bank, host_nbytes, drop_cnt
   );

endinterface

// File: rtl/iob_eth_rx_ctrl.sv
// Schedules the Ethernet receiver over a two-bank RX buffer: arms a free bank, commits
// CRC-good frames into an in-order host queue and stalls the receiver while both banks are full.
module iob_eth_rx_ctrl
   import iob_eth_rx_ctrl_pkg::*;
#(
   parameter int BUF_ADDR_W = 11,
   parameter int ARM_CYC    = 2,
   parameter int DROP_W     = 16
) (
   input logic               i_clk,
   input logic               i_rst,
   input logic               i_enable,
   iob_eth_rx_ctrl_if.slave  io_bus
);

   localparam int                CNT_W    = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
   localparam logic [CNT_W-1:0]  ARM_LAST = CNT_W'(ARM_CYC - 1);
   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_ready_q;
   logic [CNT_W-1:0]      r_arm_cnt;
   logic                  r_rx_bank;
   logic                  w_rx_bank_nxt;
   logic                  r_rearm;
   logic                  w_rearm_nxt;
   logic [NUM_BANKS-1:0]  r_full;
   logic                  r_rd_ptr;
   logic [BUF_ADDR_W-1:0] r_nbytes [0:NUM_BANKS-1];
   logic                  r_host_valid;
   logic [BUF_ADDR_W-1:0] r_host_nbytes;
   logic [DROP_W-1:0]     r_drop_cnt;

   logic                  w_commit;
   logic                  w_ack;
   logic                  w_free_bank;
   logic [NUM_BANKS-1:0]  w_clr;
   logic [NUM_BANKS-1:0]  w_set;
   logic [NUM_BANKS-1:0]  w_full_nxt;
   logic                  w_rd_ptr_nxt;
   logic [BUF_ADDR_W-1:0] w_host_nbytes_nxt;

   // Only a fresh rising edge of rx_ready in WAIT commits; a level already high on entry does not.
   assign w_commit     = (r_state == ST_WAIT) & i_enable & io_bus.rx_ready & ~r_ready_q;
   assign w_ack        = io_bus.host_ack & (|r_full);
   assign w_free_bank  = pick_free_bank(r_full, r_rd_ptr);
   assign w_clr        = w_ack    ? (2'b01 << r_rd_ptr)  : 2'b00;
   assign w_set        = w_commit ? (2'b01 << r_rx_bank) : 2'b00;
   assign w_full_nxt   = (r_full & ~w_clr) | w_set;
   assign w_rd_ptr_nxt = r_rd_ptr ^ w_ack;
   assign w_host_nbytes_nxt = (w_commit && (r_rx_bank == w_rd_ptr_nxt)) ? io_bus.rx_nbytes
                                                                       : r_nbytes[w_rd_ptr_nxt];

   // State register with arm counter, receiver bank select and registered re-arm output.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_DIS;
         r_arm_cnt <= {CNT_W{1'b0}};
         r_rx_bank <= 1'b0;
         r_rearm   <= 1'b1;
         r_ready_q <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_arm_cnt <= ((r_state == ST_ARM) && (w_state_nxt == ST_ARM)) ? r_arm_cnt + CNT_W'(1)
                                                                       : {CNT_W{1'b0}};
         r_rx_bank <= w_rx_bank_nxt;
         r_rearm   <= w_rearm_nxt;
         r_ready_q <= io_bus.rx_ready;
      end
   end

   // Next-state logic; leaving DIS re-checks bank occupancy since the stall may have been interrupted.
   always_comb begin
      w_state_nxt   = r_state;
      w_rx_bank_nxt = r_rx_bank;
      case (r_state)
         ST_DIS: begin
            if (!i_enable) begin
               w_state_nxt = ST_DIS;
            end else if (&r_full) begin
               w_state_nxt = ST_STALL;
            end else begin
               w_state_nxt   = ST_ARM;
               w_rx_bank_nxt = w_free_bank;
            end
         end
         ST_ARM: begin
            if (!i_enable) begin
               w_state_nxt = ST_DIS;
            end else if (r_arm_cnt == ARM_LAST) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_state_nxt = ST_ARM;
            end
         end
         ST_WAIT: begin
            if (!i_enable) begin
               w_state_nxt = ST_DIS;
            end else if (w_commit) begin
               w_state_nxt = ST_SW;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_SW: begin
            if (!r_full[~r_rx_bank]) begin
               w_state_nxt   = ST_ARM;
               w_rx_bank_nxt = ~r_rx_bank;
            end else begin
               w_state_nxt = ST_STALL;
            end
         end
         ST_STALL: begin
            if (!i_enable) begin
               w_state_nxt = ST_DIS;
            end else if (!(&r_full)) begin
               w_state_nxt   = ST_ARM;
               w_rx_bank_nxt = w_free_bank;
            end else begin
               w_state_nxt = ST_STALL;
            end
         end
         default: begin
            w_state_nxt   = ST_DIS;
            w_rx_bank_nxt = 1'b0;
         end
      endcase
   end

   // Output decode from the next state so rx_rearm is registered without an extra cycle of lag.
   always_comb begin
      w_rearm_nxt = 1'b1;
      case (w_state_nxt)
         ST_WAIT: w_rearm_nxt = 1'b0;
         ST_SW:   w_rearm_nxt = 1'b0;
         default: w_rearm_nxt = 1'b1;
      endcase
   end

   // Two-entry host queue; commit and ack on different banks both land on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full        <= 2'b00;
         r_rd_ptr      <= 1'b0;
         r_nbytes[0]   <= {BUF_ADDR_W{1'b0}};
         r_nbytes[1]   <= {BUF_ADDR_W{1'b0}};
         r_host_valid  <= 1'b0;
         r_host_nbytes <= {BUF_ADDR_W{1'b0}};
      end else begin
         r_full        <= w_full_nxt;
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_host_valid  <= |w_full_nxt;
         r_host_nbytes <= w_host_nbytes_nxt;
         if (w_commit) begin
            r_nbytes[r_rx_bank] <= io_bus.rx_nbytes;
         end
      end
   end

   // Saturating count of frames started on the line while the receiver is stalled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drop_cnt <= {DROP_W{1'b0}};
      end else if ((r_state == ST_STALL) && io_bus.rx_sof && (r_drop_cnt != DROP_MAX)) begin
         r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
   end

   assign io_bus.rx_rearm    = r_rearm;
   assign io_bus.rx_bank     = r_rx_bank;
   assign io_bus.host_valid  = r_host_valid;
   assign io_bus.host_bank   = r_rd_ptr;
   assign io_bus.host_nbytes = r_host_nbytes;
   assign io_bus.drop_cnt    = r_drop_cnt;

endmodule
